// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   XLEN            data/address width
//   RD_* / WR_*     memory read/write control encodings seen on rd_ctrl/wr_ctrl
//   arb_state_e     arbiter FSM states
//   STREAK_W        width of the LSU streak counter (covers MAX_LSU_STREAK up to 15)
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LBU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LHU  = 3'b100;
    localparam logic [2:0] RD_LW   = 3'b101;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_SB   = 2'b01;
    localparam logic [1:0] WR_SH   = 2'b10;
    localparam logic [1:0] WR_SW   = 2'b11;

    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRspIfu = 2'b01,
        StRspLsu = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-port bundle for mem_port_arbiter.
//   ifu_req_* / ifu_rsp_*   instruction-fetch request/response
//   lsu_req_* / lsu_rsp_*   load/store request/response
//   mem_*                   single shared memory port (mem_rdata is asynchronous)
// Modports:
//   slave   the arbiter itself
//   master  everything around it (requesters and memory)
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_rsp_valid;
    logic            ifu_rsp_ready;
    logic [XLEN-1:0] ifu_rsp_data;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [2:0]      lsu_rd_ctrl;
    logic [1:0]      lsu_wr_ctrl;
    logic [XLEN-1:0] lsu_req_addr;
    logic [XLEN-1:0] lsu_req_wdata;
    logic            lsu_rsp_valid;
    logic            lsu_rsp_ready;
    logic [XLEN-1:0] lsu_rsp_data;

    logic [2:0]      mem_rd_ctrl;
    logic [1:0]      mem_wr_ctrl;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        input  lsu_req_valid, lsu_rd_ctrl, lsu_wr_ctrl, lsu_req_addr, lsu_req_wdata,
        input  lsu_rsp_ready, mem_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_rd_ctrl, mem_wr_ctrl, mem_addr, mem_wdata
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        output lsu_req_valid, lsu_rd_ctrl, lsu_wr_ctrl, lsu_req_addr, lsu_req_wdata,
        output lsu_rsp_ready, mem_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_rd_ctrl, mem_wr_ctrl, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rsp_reg.sv
// Per-requester response register: captures data on a grant, holds valid and data
// until the requester accepts, clears on synchronous reset.
//   clk, rst       clock, synchronous active-high reset
//   capture        load capture_data and raise rsp_valid
//   capture_data   value to hold
//   rsp_ready      requester consumes the held response
//   rsp_valid      response held
//   rsp_data       held response value
module mem_port_arbiter_rsp_reg
    import mem_port_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [XLEN-1:0] capture_data,
    input  logic            rsp_ready,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data
);

    logic            valid_q;
    logic [XLEN-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            data_q  <= capture_data;
        end else if (valid_q && rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch (word reads) and the
// load/store unit. One transaction in flight; every grant answers one cycle later from a
// registered response, so throughput is at most one transaction per two cycles.
//   clk, rst   clock, synchronous active-high reset
//   bus        mem_port_arbiter_if.slave: IFU/LSU request+response handshakes, memory port
// Parameter MAX_LSU_STREAK (1..15): LSU grants allowed back to back while IFU waits.
// Optional macro MEM_ARB_PERF_EN adds 32-bit wrapping counters perf_ifu_grants,
// perf_lsu_grants and perf_ifu_stall (cycles IFU requests without being accepted).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LSU_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_ifu_grants,
    output logic [31:0]        perf_lsu_grants,
    output logic [31:0]        perf_ifu_stall
`endif
);

    localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_LSU_STREAK);

    arb_state_e          state_q;
    logic [STREAK_W-1:0] streak_q;
    logic                idle;
    logic                ifu_win;
    logic                lsu_win;
    logic [XLEN-1:0]     lsu_cap_data;

    // Grants only happen in IDLE and never while reset is asserted, which also keeps the
    // memory controls at zero during reset.
    assign idle    = !rst && (state_q == StIdle);
    assign ifu_win = idle && bus.ifu_req_valid &&
                     (!bus.lsu_req_valid || (streak_q == StreakMax));
    assign lsu_win = idle && bus.lsu_req_valid && !ifu_win;

    // Pure stores and no-op requests answer with 0; a combined read+write returns the
    // pre-write value seen on mem_rdata in the grant cycle.
    assign lsu_cap_data = (bus.lsu_rd_ctrl != RD_NONE) ? bus.mem_rdata : '0;

    always_comb begin
        bus.ifu_req_ready = ifu_win;
        bus.lsu_req_ready = lsu_win;
        bus.mem_rd_ctrl   = RD_NONE;
        bus.mem_wr_ctrl   = WR_NONE;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        if (ifu_win) begin
            bus.mem_rd_ctrl = RD_LW;
            bus.mem_addr    = bus.ifu_req_addr;
        end else if (lsu_win) begin
            bus.mem_rd_ctrl = bus.lsu_rd_ctrl;
            bus.mem_wr_ctrl = bus.lsu_wr_ctrl;
            bus.mem_addr    = bus.lsu_req_addr;
            bus.mem_wdata   = bus.lsu_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            streak_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ifu_win) begin
                        state_q <= StRspIfu;
                    end else if (lsu_win) begin
                        state_q <= StRspLsu;
                    end
                end
                StRspIfu: if (bus.ifu_rsp_ready) state_q <= StIdle;
                StRspLsu: if (bus.lsu_rsp_ready) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase

            // Streak only measures how long IFU has been starved by the LSU.
            if (!bus.ifu_req_valid || ifu_win) begin
                streak_q <= '0;
            end else if (lsu_win && (streak_q != StreakMax)) begin
                streak_q <= streak_q + STREAK_W'(1);
            end
        end
    end

    mem_port_arbiter_rsp_reg u_ifu_rsp (
        .clk          (clk),
        .rst          (rst),
        .capture      (ifu_win),
        .capture_data (bus.mem_rdata),
        .rsp_ready    (bus.ifu_rsp_ready),
        .rsp_valid    (bus.ifu_rsp_valid),
        .rsp_data     (bus.ifu_rsp_data)
    );

    mem_port_arbiter_rsp_reg u_lsu_rsp (
        .clk          (clk),
        .rst          (rst),
        .capture      (lsu_win),
        .capture_data (lsu_cap_data),
        .rsp_ready    (bus.lsu_rsp_ready),
        .rsp_valid    (bus.lsu_rsp_valid),
        .rsp_data     (bus.lsu_rsp_data)
    );

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ifu_grants_q;
    logic [31:0] perf_lsu_grants_q;
    logic [31:0] perf_ifu_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ifu_grants_q <= '0;
            perf_lsu_grants_q <= '0;
            perf_ifu_stall_q  <= '0;
        end else begin
            if (ifu_win) perf_ifu_grants_q <= perf_ifu_grants_q + 32'd1;
            if (lsu_win) perf_lsu_grants_q <= perf_lsu_grants_q + 32'd1;
            if (bus.ifu_req_valid && !ifu_win) perf_ifu_stall_q <= perf_ifu_stall_q + 32'd1;
        end
    end

    assign perf_ifu_grants = perf_ifu_grants_q;
    assign perf_lsu_grants = perf_lsu_grants_q;
    assign perf_ifu_stall  = perf_ifu_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-addressable memory model that
// performs load sign/zero extension and byte/half/word stores.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   wr_count;
    int   wr_base;

    mem_port_arbiter_if bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ifu_grants;
    logic [31:0] perf_lsu_grants;
    logic [31:0] perf_ifu_stall;
`endif

    mem_port_arbiter #(
        .MAX_LSU_STREAK (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_ifu_grants (perf_ifu_grants),
        .perf_lsu_grants (perf_lsu_grants),
        .perf_ifu_stall  (perf_ifu_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 256 words, preloaded while rst is high.
    logic [31:0] mem_words [0:255];
    logic [7:0]  mem_idx;
    logic [31:0] word_rd;
    logic [31:0] shifted;

    assign mem_idx = bus.mem_addr[9:2];

    always_comb begin
        word_rd = mem_words[mem_idx];
        shifted = word_rd >> {bus.mem_addr[1:0], 3'b000};
        case (bus.mem_rd_ctrl)
            RD_LB:   bus.mem_rdata = {{24{shifted[7]}}, shifted[7:0]};
            RD_LBU:  bus.mem_rdata = {24'h0, shifted[7:0]};
            RD_LH:   bus.mem_rdata = {{16{shifted[15]}}, shifted[15:0]};
            RD_LHU:  bus.mem_rdata = {16'h0, shifted[15:0]};
            RD_LW:   bus.mem_rdata = word_rd;
            default: bus.mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            mem_words[8'h40] <= 32'h0000_0013;
            mem_words[8'h80] <= 32'h8000_0000;
            mem_words[8'h10] <= 32'h0000_0000;
            mem_words[8'h11] <= 32'h1111_1111;
        end else begin
            case (bus.mem_wr_ctrl)
                WR_SB: mem_words[mem_idx][{bus.mem_addr[1:0], 3'b000} +: 8] <=
                           bus.mem_wdata[7:0];
                WR_SH: mem_words[mem_idx][{bus.mem_addr[1], 4'b0000} +: 16] <=
                           bus.mem_wdata[15:0];
                WR_SW: mem_words[mem_idx] <= bus.mem_wdata;
                default: ;
            endcase
            if (bus.mem_wr_ctrl != WR_NONE) wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One IFU read: grant this cycle, response valid next cycle, gone after that.
    task automatic ifu_txn(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = addr;
        #1;
        check({tag, ".req_ready"}, 32'(bus.ifu_req_ready), 32'h1);
        check({tag, ".mem_rd"},    32'(bus.mem_rd_ctrl),   32'(RD_LW));
        check({tag, ".mem_addr"},  bus.mem_addr,           addr);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        #1;
        check({tag, ".rsp_valid"}, 32'(bus.ifu_rsp_valid), 32'h1);
        check({tag, ".rsp_data"},  bus.ifu_rsp_data,       exp);
        check({tag, ".rsp_nogrant"}, 32'(bus.mem_rd_ctrl), 32'h0);
        @(negedge clk);
        #1;
        check({tag, ".rsp_done"},  32'(bus.ifu_rsp_valid), 32'h0);
    endtask

    task automatic lsu_txn(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp);
        @(negedge clk);
        bus.lsu_req_valid = 1'b1;
        bus.lsu_rd_ctrl   = rd;
        bus.lsu_wr_ctrl   = wr;
        bus.lsu_req_addr  = addr;
        bus.lsu_req_wdata = wdata;
        #1;
        check({tag, ".req_ready"}, 32'(bus.lsu_req_ready), 32'h1);
        check({tag, ".mem_rd"},    32'(bus.mem_rd_ctrl),   32'(rd));
        check({tag, ".mem_wr"},    32'(bus.mem_wr_ctrl),   32'(wr));
        check({tag, ".mem_addr"},  bus.mem_addr,           addr);
        check({tag, ".mem_wdata"}, bus.mem_wdata,          wdata);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        #1;
        check({tag, ".rsp_valid"}, 32'(bus.lsu_rsp_valid), 32'h1);
        check({tag, ".rsp_data"},  bus.lsu_rsp_data,       exp);
        check({tag, ".rsp_wr_off"}, 32'(bus.mem_wr_ctrl),  32'h0);
        @(negedge clk);
        #1;
        check({tag, ".rsp_done"},  32'(bus.lsu_rsp_valid), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_count = 0;

        // Reset with both requesters asking, LSU presenting a store.
        rst               = 1'b1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h100;
        bus.ifu_rsp_ready = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_rd_ctrl   = RD_NONE;
        bus.lsu_wr_ctrl   = WR_SW;
        bus.lsu_req_addr  = 32'h40;
        bus.lsu_req_wdata = 32'hCAFE_F00D;
        bus.lsu_rsp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst.ifu_ready", 32'(bus.ifu_req_ready), 32'h0);
            check("rst.lsu_ready", 32'(bus.lsu_req_ready), 32'h0);
            check("rst.mem_wr",    32'(bus.mem_wr_ctrl),   32'h0);
            check("rst.ifu_rspv",  32'(bus.ifu_rsp_valid), 32'h0);
            check("rst.lsu_rspv",  32'(bus.lsu_rsp_valid), 32'h0);
            check("rst.ifu_data",  bus.ifu_rsp_data,       32'h0);
        end
        @(negedge clk);
        rst               = 1'b0;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_wr_ctrl   = WR_NONE;
        #1;
        check("rst.no_writes", 32'(wr_count), 32'h0);

        ifu_txn("ifu_0x100", 32'h100, 32'h0000_0013);

        lsu_txn("lb",  RD_LB,  WR_NONE, 32'h203, 32'h0, 32'hFFFF_FF80);
        lsu_txn("lbu", RD_LBU, WR_NONE, 32'h203, 32'h0, 32'h0000_0080);
        lsu_txn("lh",  RD_LH,  WR_NONE, 32'h202, 32'h0, 32'hFFFF_8000);
        lsu_txn("lhu", RD_LHU, WR_NONE, 32'h202, 32'h0, 32'h0000_8000);

        wr_base = wr_count;
        lsu_txn("sw", RD_NONE, WR_SW, 32'h40, 32'hDEAD_BEEF, 32'h0);
        check("sw.one_write", 32'(wr_count - wr_base), 32'h1);
        ifu_txn("ifu_0x40", 32'h40, 32'hDEAD_BEEF);

        wr_base = wr_count;
        lsu_txn("nop", RD_NONE, WR_NONE, 32'h80, 32'h5555_5555, 32'h0);
        check("nop.no_write", 32'(wr_count - wr_base), 32'h0);

        lsu_txn("lw_sw", RD_LW, WR_SW, 32'h44, 32'h2222_2222, 32'h1111_1111);
        ifu_txn("ifu_0x44", 32'h44, 32'h2222_2222);

        // Both requesting every cycle: expected grants L,L,L,L,I,L,L,L,L,I.
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_rd_ctrl   = RD_LW;
        bus.lsu_wr_ctrl   = WR_NONE;
        bus.lsu_req_addr  = 32'h40;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("streak.lsu%0d", i), 32'(bus.lsu_req_ready), 32'((i % 5) != 4));
            check($sformatf("streak.ifu%0d", i), 32'(bus.ifu_req_ready), 32'((i % 5) == 4));
            @(negedge clk);
            #1;
            check($sformatf("streak.rsp%0d", i),
                  32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'h0);
            @(negedge clk);
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;

        // LSU response back-pressured for five cycles while IFU waits.
        @(negedge clk);
        bus.lsu_req_valid = 1'b1;
        bus.lsu_rd_ctrl   = RD_LW;
        bus.lsu_req_addr  = 32'h40;
        bus.lsu_rsp_ready = 1'b0;
        #1;
        check("hold.grant", 32'(bus.lsu_req_ready), 32'h1);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold.valid%0d", i), 32'(bus.lsu_rsp_valid), 32'h1);
            check($sformatf("hold.data%0d", i),  bus.lsu_rsp_data,       32'hDEAD_BEEF);
            check($sformatf("hold.nogrant%0d", i),
                  32'({bus.ifu_req_ready, bus.mem_rd_ctrl}), 32'h0);
            @(negedge clk);
        end
        bus.lsu_rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("hold.released", 32'(bus.lsu_rsp_valid), 32'h0);
        check("hold.ifu_grant", 32'(bus.ifu_req_ready), 32'h1);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        #1;
        check("hold.ifu_data", bus.ifu_rsp_data, 32'h0000_0013);

        // Reset while a response is pending.
        @(negedge clk);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h100;
        bus.ifu_rsp_ready = 1'b0;
        #1;
        check("rstrsp.grant", 32'(bus.ifu_req_ready), 32'h1);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        #1;
        check("rstrsp.valid", 32'(bus.ifu_rsp_valid), 32'h1);
        rst = 1'b1;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_rd_ctrl   = RD_NONE;
        bus.lsu_wr_ctrl   = WR_SW;
        #1;
        check("rstrsp.mem_wr", 32'(bus.mem_wr_ctrl), 32'h0);
        @(negedge clk);
        rst               = 1'b0;
        bus.ifu_rsp_ready = 1'b1;
        bus.lsu_rd_ctrl   = RD_LW;
        bus.lsu_wr_ctrl   = WR_NONE;
        bus.lsu_req_addr  = 32'h44;
        #1;
        check("rstrsp.dropped", 32'(bus.ifu_rsp_valid), 32'h0);
        check("rstrsp.idle",    32'(bus.lsu_req_ready), 32'h1);
        @(negedge clk);
        bus.lsu_req_valid = 1'b0;
        #1;
        check("rstrsp.lsu_data", bus.lsu_rsp_data, 32'h1111_1111);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
